// File: rtl/axi_lite_write_pkg.sv
// Shared definitions for the AXI4-Lite write-channel engine: state encoding and response codes.
package axi_lite_write_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] BRESP = 2'd2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WDATA = WDATA,
        ST_BRESP = BRESP
    } wr_state_t;

endpackage

// File: rtl/axi_lite_write.sv
// AXI4-Lite write-channel engine: one AW, one W, one OKAY B; emits a one-cycle register strobe.
// Optional byte-enable path (wstrb -> reg_data_be) is enabled by defining AXI_LITE_WRITE_WSTRB_EN.
module axi_lite_write
    import axi_lite_write_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 10,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic [C_ADDR_WIDTH-1:0] awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [C_DATA_WIDTH-1:0] wdata,
    input  logic                    bready,
    output logic                    bvalid,
    output logic [1:0]              bresp,
    output logic [C_ADDR_WIDTH-1:0] reg_data_addr,
    output logic                    reg_data_write,
    output logic [C_DATA_WIDTH-1:0] reg_data
`ifdef AXI_LITE_WRITE_WSTRB_EN
    ,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    output logic [C_DATA_WIDTH/8-1:0] reg_data_be
`endif
);

    wr_state_t               state_q, state_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic                    write_q, write_d;
    logic [1:0]              bresp_q;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
`ifdef AXI_LITE_WRITE_WSTRB_EN
    logic [C_DATA_WIDTH/8-1:0] be_q, be_d;
`endif

    // Next-state and capture logic; the strobe defaults low so it can only pulse for one cycle.
    always_comb begin
        state_d  = state_q;
        wready_d = wready_q;
        bvalid_d = bvalid_q;
        write_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
`ifdef AXI_LITE_WRITE_WSTRB_EN
        be_d     = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (awvalid && awready) begin
                    addr_d   = awaddr;
                    wready_d = 1'b1;
                    state_d  = ST_WDATA;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (wvalid && wready_q) begin
                    data_d   = wdata;
`ifdef AXI_LITE_WRITE_WSTRB_EN
                    be_d     = wstrb;
`endif
                    write_d  = 1'b1;
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    state_d  = ST_BRESP;
                end else begin
                    state_d  = ST_WDATA;
                end
            end
            ST_BRESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_BRESP;
                end
            end
            default: begin
                wready_d = 1'b0;
                bvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            write_q  <= 1'b0;
            bresp_q  <= 2'b00;
            addr_q   <= {C_ADDR_WIDTH{1'b0}};
            data_q   <= {C_DATA_WIDTH{1'b0}};
`ifdef AXI_LITE_WRITE_WSTRB_EN
            be_q     <= {(C_DATA_WIDTH/8){1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            wready_q <= wready_d;
            bvalid_q <= bvalid_d;
            write_q  <= write_d;
            bresp_q  <= RESP_OKAY;
            addr_q   <= addr_d;
            data_q   <= data_d;
`ifdef AXI_LITE_WRITE_WSTRB_EN
            be_q     <= be_d;
`endif
        end
    end

    assign wready         = wready_q;
    assign bvalid         = bvalid_q;
    assign bresp          = bresp_q;
    assign reg_data_write = write_q;
    assign reg_data_addr  = addr_q;
    assign reg_data       = data_q;
`ifdef AXI_LITE_WRITE_WSTRB_EN
    assign reg_data_be    = be_q;
`endif

endmodule

// File: tb/tb_axi_lite_write.sv
// Directed bench for axi_lite_write: inputs driven and outputs checked on the falling edge.
module tb_axi_lite_write;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready;
    logic [9:0]  awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [9:0]  reg_data_addr;
    logic        reg_data_write;
    logic [31:0] reg_data;
`ifdef AXI_LITE_WRITE_WSTRB_EN
    logic [3:0]  wstrb;
    logic [3:0]  reg_data_be;
`endif

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int snap;

    axi_lite_write #(.C_ADDR_WIDTH(10), .C_DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bready(bready), .bvalid(bvalid), .bresp(bresp),
        .reg_data_addr(reg_data_addr), .reg_data_write(reg_data_write), .reg_data(reg_data)
`ifdef AXI_LITE_WRITE_WSTRB_EN
        , .wstrb(wstrb), .reg_data_be(reg_data_be)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_data_write === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; awvalid = 1'b0; awready = 1'b0; awaddr = 10'h000;
        wvalid = 1'b0; wdata = 32'h0; bready = 1'b0;
`ifdef AXI_LITE_WRITE_WSTRB_EN
        wstrb = 4'hF;
`endif
        step(); step();
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_strobe", {31'd0, reg_data_write}, 32'd0);
        check("rst_addr", {22'd0, reg_data_addr}, 32'd0);
        check("rst_data", reg_data, 32'd0);
        reset = 1'b0;

        // Single write, bready high
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h010; bready = 1'b1;
        step();
        check("single_wready", {31'd0, wready}, 32'd1);
        check("single_addr_latched", {22'd0, reg_data_addr}, 32'h010);
        check("single_no_early_strobe", {31'd0, reg_data_write}, 32'd0);
        awvalid = 1'b0; awready = 1'b0; wvalid = 1'b1; wdata = 32'hDEADBEEF;
        step();
        check("single_strobe", {31'd0, reg_data_write}, 32'd1);
        check("single_addr", {22'd0, reg_data_addr}, 32'h010);
        check("single_data", reg_data, 32'hDEADBEEF);
        check("single_bvalid", {31'd0, bvalid}, 32'd1);
        check("single_bresp", {30'd0, bresp}, 32'd0);
        check("single_wready_low", {31'd0, wready}, 32'd0);
        wvalid = 1'b0;
        step();
        check("single_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("single_strobe_drop", {31'd0, reg_data_write}, 32'd0);

        // Early W, then B backpressure
        bready = 1'b0; wvalid = 1'b1; wdata = 32'h01020304;
        for (int i = 0; i < 3; i++) begin
            step();
            check("early_wready_low", {31'd0, wready}, 32'd0);
            check("early_no_strobe", {31'd0, reg_data_write}, 32'd0);
        end
        check("early_data_not_sampled", reg_data, 32'hDEADBEEF);
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h004;
        step();
        check("early_wready_after_aw", {31'd0, wready}, 32'd1);
        check("early_no_strobe_aw_cycle", {31'd0, reg_data_write}, 32'd0);
        awvalid = 1'b0; awready = 1'b0;
        snap = strobe_cnt;
        step();
        check("early_strobe", {31'd0, reg_data_write}, 32'd1);
        check("early_addr", {22'd0, reg_data_addr}, 32'h004);
        check("early_data", reg_data, 32'h01020304);
        check("early_bvalid", {31'd0, bvalid}, 32'd1);
        wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
            check("bp_bresp", {30'd0, bresp}, 32'd0);
            check("bp_no_strobe", {31'd0, reg_data_write}, 32'd0);
        end
        bready = 1'b1;
        step();
        check("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("bp_single_strobe", strobe_cnt - snap, 32'd1);

        // Back-to-back writes with bready tied high
        snap = strobe_cnt;
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h000; wvalid = 1'b1; wdata = 32'h11223344;
        step();
        check("b2b0_wready", {31'd0, wready}, 32'd1);
        awvalid = 1'b0; awready = 1'b0;
        step();
        check("b2b0_strobe", {31'd0, reg_data_write}, 32'd1);
        check("b2b0_addr", {22'd0, reg_data_addr}, 32'h000);
        check("b2b0_data", reg_data, 32'h11223344);
        check("b2b0_bvalid", {31'd0, bvalid}, 32'd1);
        wvalid = 1'b0;
        step();
        check("b2b0_bvalid_one_cycle", {31'd0, bvalid}, 32'd0);
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h008; wvalid = 1'b1; wdata = 32'h55667788;
        step();
        check("b2b1_wready", {31'd0, wready}, 32'd1);
        check("b2b1_data_held", reg_data, 32'h11223344);
        awvalid = 1'b0; awready = 1'b0;
        step();
        check("b2b1_strobe", {31'd0, reg_data_write}, 32'd1);
        check("b2b1_addr", {22'd0, reg_data_addr}, 32'h008);
        check("b2b1_data", reg_data, 32'h55667788);
        check("b2b1_bvalid", {31'd0, bvalid}, 32'd1);
        wvalid = 1'b0;
        step();
        check("b2b1_bvalid_one_cycle", {31'd0, bvalid}, 32'd0);
        step();
        check("b2b_strobe_count", strobe_cnt - snap, 32'd2);

        // Reset mid-BRESP aborts, then a fresh write is accepted
        bready = 1'b0;
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h020; wvalid = 1'b1; wdata = 32'hCAFEF00D;
        step();
        awvalid = 1'b0; awready = 1'b0;
        step();
        check("mid_bvalid", {31'd0, bvalid}, 32'd1);
        wvalid = 1'b0; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("mid_rst_wready", {31'd0, wready}, 32'd0);
        check("mid_rst_strobe", {31'd0, reg_data_write}, 32'd0);
        check("mid_rst_data", reg_data, 32'd0);
        snap = strobe_cnt;
        bready = 1'b1;
        awvalid = 1'b1; awready = 1'b1; awaddr = 10'h3FC;
        step();
        check("post_rst_wready", {31'd0, wready}, 32'd1);
        check("post_rst_addr", {22'd0, reg_data_addr}, 32'h3FC);
        check("post_rst_no_stale_b", {31'd0, bvalid}, 32'd0);
        awvalid = 1'b0; awready = 1'b0; wvalid = 1'b1; wdata = 32'hAABBCCDD;
`ifdef AXI_LITE_WRITE_WSTRB_EN
        wstrb = 4'b0101;
`endif
        step();
        check("post_rst_strobe", {31'd0, reg_data_write}, 32'd1);
        check("post_rst_data", reg_data, 32'hAABBCCDD);
`ifdef AXI_LITE_WRITE_WSTRB_EN
        check("wstrb_be", {28'd0, reg_data_be}, 32'h5);
`endif
        wvalid = 1'b0;
        step();
        check("post_rst_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("post_rst_strobe_count", strobe_cnt - snap, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
